// File: rtl/divider32.sv
// Iterative 32-bit restoring divider for DIV/DIVU: quotient to LO (oQ), remainder to HI (oR).
// Signed division is built only when DIVIDER32_SIGNED_EN is defined; otherwise every division is unsigned.
module divider32 (
  input  logic        iClk,
  input  logic        iRst,
  input  logic        iStart,
  input  logic        iSigned,
  input  logic [31:0] iDividend,
  input  logic [31:0] iDivisor,
  output logic        oBusy,
  output logic        oDone,
  output logic [31:0] oQ,
  output logic [31:0] oR,
  output logic        oDivZero
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] rem_q, rem_d;      // partial remainder
  logic [31:0] dvd_q, dvd_d;      // dividend shifts out as quotient bits shift in
  logic [31:0] dsr_q, dsr_d;      // divisor magnitude
  logic        q_sign_q, q_sign_d;
  logic        r_sign_q, r_sign_d;
  logic        div_zero_q, div_zero_d;
  logic [31:0] q_out_q, q_out_d;
  logic [31:0] r_out_q, r_out_d;
  logic        done_q, done_d;

  logic        dvd_neg, dsr_neg;
  logic [31:0] dvd_mag, dsr_mag;
  logic [32:0] rem_shift, trial;
  logic [31:0] q_fix, r_fix;

`ifdef DIVIDER32_SIGNED_EN
  always_comb begin
    dvd_neg = iSigned & iDividend[31];
    dsr_neg = iSigned & iDivisor[31];
    dvd_mag = dvd_neg ? -iDividend : iDividend;
    dsr_mag = dsr_neg ? -iDivisor : iDivisor;
    q_fix   = q_sign_q ? -dvd_q : dvd_q;
    r_fix   = r_sign_q ? -rem_q : rem_q;
  end
`else
  logic unused_signed;
  assign unused_signed = iSigned;

  always_comb begin
    dvd_neg = 1'b0;
    dsr_neg = 1'b0;
    dvd_mag = iDividend;
    dsr_mag = iDivisor;
    q_fix   = dvd_q;
    r_fix   = rem_q;
  end
`endif

  // Trial subtract is 33 bits wide: the shifted remainder can exceed 32 bits,
  // and bit 32 of the difference is the borrow that decides restore vs keep.
  always_comb begin
    rem_shift = {rem_q, dvd_q[31]};
    trial     = rem_shift - {1'b0, dsr_q};
  end

  // NOTE: every signal assigned in this block gets a default first, so no
  // path through the case leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rem_d      = rem_q;
    dvd_d      = dvd_q;
    dsr_d      = dsr_q;
    q_sign_d   = q_sign_q;
    r_sign_d   = r_sign_q;
    div_zero_d = div_zero_q;
    q_out_d    = q_out_q;
    r_out_d    = r_out_q;
    done_d     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (iStart) begin
          dvd_d      = dvd_mag;
          dsr_d      = dsr_mag;
          q_sign_d   = dvd_neg ^ dsr_neg;
          r_sign_d   = dvd_neg;
          div_zero_d = (iDivisor == 32'd0);
          cnt_d      = 6'd0;
          rem_d      = 32'd0;
          state_d    = S_RUN;
        end
      end
      S_RUN: begin
        if (trial[32]) begin
          rem_d = rem_shift[31:0];
          dvd_d = {dvd_q[30:0], 1'b0};
        end else begin
          rem_d = trial[31:0];
          dvd_d = {dvd_q[30:0], 1'b1};
        end
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'd31) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        q_out_d = q_fix;
        r_out_d = r_fix;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_q    <= S_IDLE;
      cnt_q      <= 6'd0;
      rem_q      <= 32'd0;
      dvd_q      <= 32'd0;
      dsr_q      <= 32'd0;
      q_sign_q   <= 1'b0;
      r_sign_q   <= 1'b0;
      div_zero_q <= 1'b0;
      q_out_q    <= 32'd0;
      r_out_q    <= 32'd0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rem_q      <= rem_d;
      dvd_q      <= dvd_d;
      dsr_q      <= dsr_d;
      q_sign_q   <= q_sign_d;
      r_sign_q   <= r_sign_d;
      div_zero_q <= div_zero_d;
      q_out_q    <= q_out_d;
      r_out_q    <= r_out_d;
      done_q     <= done_d;
    end
  end

  assign oBusy    = (state_q != S_IDLE);
  assign oDone    = done_q;
  assign oQ       = q_out_q;
  assign oR       = r_out_q;
  assign oDivZero = div_zero_q;

endmodule

// File: tb/tb_divider32.sv
// Directed self-checking bench for divider32: vector table plus hand-written
// sequences for start-while-busy and mid-run reset. Expectations follow DIVIDER32_SIGNED_EN.
module tb_divider32;

  logic        iClk = 1'b0;
  logic        iRst;
  logic        iStart;
  logic        iSigned;
  logic [31:0] iDividend;
  logic [31:0] iDivisor;
  logic        oBusy;
  logic        oDone;
  logic [31:0] oQ;
  logic [31:0] oR;
  logic        oDivZero;

  int n_checks = 0;
  int n_errors = 0;

  divider32 dut (
    .iClk      (iClk),
    .iRst      (iRst),
    .iStart    (iStart),
    .iSigned   (iSigned),
    .iDividend (iDividend),
    .iDivisor  (iDivisor),
    .oBusy     (oBusy),
    .oDone     (oDone),
    .oQ        (oQ),
    .oR        (oR),
    .oDivZero  (oDivZero)
  );

  always #5 iClk = ~iClk;

  typedef struct {
    string       name;
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] eq;
    logic [31:0] er;
    logic        edz;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Launch one division and follow it to oDone; optionally re-pulse iStart
  // with other operands during RUN, which must be ignored.
  task automatic do_div(input vec_t v, input bit poke);
    int cyc;
    int busy_cnt;
    bit seen;
    @(negedge iClk);
    iStart    = 1'b1;
    iSigned   = v.sgn;
    iDividend = v.a;
    iDivisor  = v.b;
    @(posedge iClk);
    #1;
    iStart    = 1'b0;
    iDividend = $urandom;
    iDivisor  = $urandom;
    iSigned   = ~v.sgn;
    busy_cnt  = oBusy ? 1 : 0;
    cyc       = 0;
    seen      = 1'b0;
    while (cyc < 60 && !seen) begin
      if (poke && (cyc == 5 || cyc == 20)) begin
        iStart    = 1'b1;
        iDividend = 32'd9 + 32'(cyc);
        iDivisor  = 32'd3;
      end else begin
        iStart    = 1'b0;
      end
      @(posedge iClk);
      #1;
      cyc++;
      if (oBusy) busy_cnt++;
      if (oDone) seen = 1'b1;
    end
    iStart = 1'b0;
    check({v.name, "_done_seen"}, 32'(seen), 32'd1);
    check({v.name, "_latency"}, 32'(cyc), 32'd33);
    check({v.name, "_busy_cycles"}, 32'(busy_cnt), 32'd33);
    check({v.name, "_q"}, oQ, v.eq);
    check({v.name, "_r"}, oR, v.er);
    check({v.name, "_divzero"}, 32'(oDivZero), 32'(v.edz));
    @(posedge iClk);
    #1;
    check({v.name, "_done_pulse_end"}, 32'(oDone), 32'd0);
    check({v.name, "_hold_q"}, oQ, v.eq);
  endtask

  initial begin
    vec_t v;
    int done_cnt;

    vecs[0] = '{"divu_100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0};
    vecs[1] = '{"divu_div0", 1'b0, 32'h12345678, 32'h0, 32'hFFFFFFFF, 32'h12345678, 1'b1};
    vecs[2] = '{"divu_max_1", 1'b0, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 32'd0, 1'b0};
    vecs[3] = '{"divu_deadbeef_16", 1'b0, 32'hDEADBEEF, 32'h10, 32'h0DEADBEE, 32'hF, 1'b0};
    vecs[4] = '{"div_5_0", 1'b1, 32'd5, 32'd0, 32'hFFFFFFFF, 32'd5, 1'b1};
`ifdef DIVIDER32_SIGNED_EN
    vecs[5] = '{"div_m7_2", 1'b1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0};
    vecs[6] = '{"div_overflow", 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0, 1'b0};
    vecs[7] = '{"div_7_m2", 1'b1, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1, 1'b0};
    vecs[8] = '{"div_m5_0", 1'b1, 32'hFFFFFFFB, 32'd0, 32'h00000001, 32'hFFFFFFFB, 1'b1};
`else
    vecs[5] = '{"div_m7_2", 1'b1, 32'hFFFFFFF9, 32'd2, 32'h7FFFFFFC, 32'd1, 1'b0};
    vecs[6] = '{"div_overflow", 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000, 1'b0};
    vecs[7] = '{"div_7_m2", 1'b1, 32'd7, 32'hFFFFFFFE, 32'd0, 32'd7, 1'b0};
    vecs[8] = '{"div_m5_0", 1'b1, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFB, 1'b1};
`endif

    // Reset, with iStart held high to confirm reset wins.
    iRst      = 1'b1;
    iStart    = 1'b1;
    iSigned   = 1'b0;
    iDividend = 32'd100;
    iDivisor  = 32'd7;
    repeat (3) @(posedge iClk);
    #1;
    iStart = 1'b0;
    check("rst_busy", 32'(oBusy), 32'd0);
    check("rst_done", 32'(oDone), 32'd0);
    check("rst_q", oQ, 32'd0);
    check("rst_r", oR, 32'd0);
    check("rst_divzero", 32'(oDivZero), 32'd0);
    @(negedge iClk);
    iRst = 1'b0;
    @(posedge iClk);
    #1;
    check("rst_start_dropped", 32'(oBusy), 32'd0);

    foreach (vecs[i]) do_div(vecs[i], 1'b0);

    // iStart re-pulsed in RUN with other operands; first operands must win.
    v = '{"busy_start_ignored", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0};
    do_div(v, 1'b1);
    v = '{"after_ignored_9_3", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 1'b0};
    do_div(v, 1'b0);

    // Leave non-zero results, then reset in the middle of RUN.
    v = '{"pre_abort", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0};
    do_div(v, 1'b0);
    @(negedge iClk);
    iStart    = 1'b1;
    iDividend = 32'd1000;
    iDivisor  = 32'd3;
    @(posedge iClk);
    #1;
    iStart = 1'b0;
    repeat (15) @(posedge iClk);
    #1;
    check("abort_busy_before", 32'(oBusy), 32'd1);
    iRst = 1'b1;
    @(posedge iClk);
    #1;
    iRst = 1'b0;
    check("abort_busy", 32'(oBusy), 32'd0);
    check("abort_done", 32'(oDone), 32'd0);
    check("abort_q", oQ, 32'd0);
    check("abort_r", oR, 32'd0);
    done_cnt = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge iClk);
      #1;
      if (oDone || oBusy) done_cnt++;
    end
    check("abort_no_done", 32'(done_cnt), 32'd0);
    v = '{"post_abort_9_3", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 1'b0};
    do_div(v, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
